// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - One-bit-per-clock UART frame receiver with parity, framing and overrun status
// Optional two-flop input synchronizer enabled by defining UART_RX_SYNC_EN.
module uart_receiver #(
    parameter int DATA_SIZE      = 8,
    parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_data_in,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    // Data bits plus the parity bit are collected before the stop bit.
    localparam logic [BIT_COUNT_SIZE-1:0] LAST_BIT = BIT_COUNT_SIZE'(DATA_SIZE);

    state_t                    state;
    state_t                    next_state;
    logic                      rx_bit;
    logic                      clear_cnt;
    logic                      shift_en;
    logic                      frame_done;
    logic [BIT_COUNT_SIZE-1:0] bit_cnt;
    logic [DATA_SIZE:0]        shift_reg;

`ifdef UART_RX_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Flops reset to the idle line level so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= serial_data_in;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_bit = sync_q2;
`else
    assign rx_bit = serial_data_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clear_cnt  = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_bit) begin
                    next_state = DATA;
                    clear_cnt  = 1'b1;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                frame_done = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // LSB arrives first, so shifting right leaves data in [DATA_SIZE-1:0] and parity on top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (clear_cnt) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_COUNT_SIZE'(1);
            end
            if (shift_en) begin
                shift_reg <= {rx_bit, shift_reg[DATA_SIZE:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_reg[DATA_SIZE-1:0];
                    parity_err <= ^shift_reg;
                    frame_err  <= ~rx_bit;
                    rx_valid   <= 1'b1;
                end else begin
                    // Consumer still holds the previous frame: drop the new one.
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, data bits per frame.
REQ-002 The block SHALL have parameter BIT_COUNT_SIZE, default $clog2(DATA_SIZE)+1, bit-counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port serial_data_in, input, 1, serial line, idle high, driven by the transmitter's serial_data_out.
REQ-006 The block SHALL have port rx_data, output, DATA_SIZE, last accepted byte.
REQ-007 The block SHALL have port rx_valid, output, 1, rx_data and status are valid.
REQ-008 The block SHALL have port rx_ready, input, 1, the consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-009 The block SHALL have ports parity_err, frame_err, overrun_err, output, 1 each, error status.

Function
REQ-010 Frame format SHALL be, one bit per clk: start (0), DATA_SIZE data bits LSB first, parity bit = XOR of data bits, stop (1); the line stays high for at least 1 cycle between frames.
REQ-011 The state machine SHALL have states IDLE, DATA, STOP.
REQ-012 IDLE: a sampled 0 SHALL clear the bit counter and move to DATA; a sampled 1 SHALL keep IDLE.
REQ-013 DATA: each cycle SHALL shift the sampled bit into a (DATA_SIZE+1)-bit shift register and increment the counter; after DATA_SIZE+1 bits it SHALL move to STOP.
REQ-014 STOP: the block SHALL sample the stop bit and return to IDLE on the next edge, whatever the bit value.
REQ-015 On the STOP edge the block SHALL compute parity_err = XOR of the data and parity bits, and frame_err = NOT stop bit.
REQ-016 A frame SHALL complete on the STOP edge; rx_valid rises DATA_SIZE+3 cycles after the cycle in which the start bit is on the line (11 for DATA_SIZE=8).
REQ-017 On completion, if rx_valid is 0, or rx_valid and rx_ready are both 1, the block SHALL load rx_data, parity_err and frame_err and hold rx_valid at 1.
REQ-018 On completion with rx_valid=1 and rx_ready=0, the block SHALL discard the new frame, keep rx_data and status, and pulse overrun_err for exactly 1 cycle.
REQ-019 If rx_valid=1 and rx_ready=1 with no completion, rx_valid SHALL fall on the next edge; parity_err and frame_err are only meaningful while rx_valid=1.
REQ-020 A frame with frame_err or parity_err SHALL still be delivered; there is no error-based suppression.
REQ-021 A low stop bit (break) SHALL give frame_err=1; if the line is still low in IDLE, a new frame starts immediately.
REQ-022 The counter SHALL be BIT_COUNT_SIZE wide and never wrap within a frame.

Reset
REQ-023 While reset_n=0, state SHALL be IDLE; counter, shift register, rx_data, rx_valid, parity_err, frame_err and overrun_err SHALL be 0; synchronizer flops SHALL be 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output; after release, reception resumes at the next start bit.

Configuration
REQ-025 With UART_RX_SYNC_EN defined, serial_data_in SHALL pass through a two-flop synchronizer before the FSM, adding exactly 2 cycles to the REQ-016 latency.
REQ-026 Without UART_RX_SYNC_EN, the FSM SHALL sample serial_data_in directly, with the REQ-016 latency.

Verification
REQ-027 Frame 0xA5, parity 0, stop 1, rx_ready=1 -> rx_valid for 1 cycle, 11 cycles after the start bit (13 with the macro); rx_data=0xA5; no errors.
REQ-028 Frame 0x01 with parity bit 0 -> rx_data=0x01, parity_err=1, frame_err=0.
REQ-029 Frame 0x3C with stop bit 0 -> frame_err=1, rx_data=0x3C; line held low -> a second frame starts in the following IDLE cycle.
REQ-030 rx_ready=0, frames 0x11 then 0x22 with 1 idle cycle between -> rx_data stays 0x11, overrun_err pulses 1 cycle at the second completion.
REQ-031 rx_ready=1 held, back-to-back frames 0x55, 0xAA, 0xFF, 2 idle cycles apart, from the transmitter -> three valid cycles in order, no errors.
REQ-032 reset_n pulsed low during data bit 4 of 0x5A, then a clean 0xC3 frame -> only 0xC3 delivered, all outputs 0 during reset.
